// File: rtl/kmap_sweeper.sv
// ============================================================================
// kmap_sweeper : steps {A,B,C,D} through 0..15 and captures F_0..F_2 truth tables
// Optional golden compare: define KMAP_SWEEP_CHECK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module kmap_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  input  logic        F_0,
  input  logic        F_1,
  input  logic        F_2,
  output logic [3:0]  idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_f0,
  output logic [15:0] tt_f1,
  output logic [15:0] tt_f2,
  output logic [2:0]  mismatch
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] c_settle = 3'(SETTLE);

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  idx_d;
  logic [3:0]  vec_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] tt_f0_q;
  logic [15:0] tt_f1_q;
  logic [15:0] tt_f2_q;
`ifdef KMAP_SWEEP_CHECK_EN
  logic [2:0]  mismatch_q;
`endif

  assign idx_d = idx_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      vec_q   <= 4'd0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_f0_q <= 16'h0000;
      tt_f1_q <= 16'h0000;
      tt_f2_q <= 16'h0000;
`ifdef KMAP_SWEEP_CHECK_EN
      mismatch_q <= 3'b000;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_DRIVE;
            busy_q  <= 1'b1;
            idx_q   <= 4'd0;
            vec_q   <= 4'd0;
            cnt_q   <= 3'd0;
            tt_f0_q <= 16'h0000;
            tt_f1_q <= 16'h0000;
            tt_f2_q <= 16'h0000;
`ifdef KMAP_SWEEP_CHECK_EN
            mismatch_q <= 3'b000;
`endif
          end
        end
        S_DRIVE: begin
          // Vector and index advance together so A..D always mirror idx.
          if (!hold) begin
            if (cnt_q == c_settle) begin
              tt_f0_q[idx_q] <= F_0;
              tt_f1_q[idx_q] <= F_1;
              tt_f2_q[idx_q] <= F_2;
              cnt_q          <= 3'd0;
              if (idx_q == 4'd15) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_d;
                vec_q <= idx_d;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
`ifdef KMAP_SWEEP_CHECK_EN
          mismatch_q <= {(tt_f2_q != 16'hF3CC),
                         (tt_f1_q != 16'hEDE0),
                         (tt_f0_q != 16'h6996)};
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {A, B, C, D} = vec_q;
  assign idx   = idx_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tt_f0 = tt_f0_q;
  assign tt_f1 = tt_f1_q;
  assign tt_f2 = tt_f2_q;
`ifdef KMAP_SWEEP_CHECK_EN
  assign mismatch = mismatch_q;
`else
  assign mismatch = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kmap_sweeper.sv
// ============================================================================
// tb_kmap_sweeper : sweeps two instances (SETTLE=1 and SETTLE=0) against a K-map model
// ============================================================================
`default_nettype none

module tb_kmap_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, hold1, start0, hold0, force_f1;
  logic a1, b1, c1, d1, a0, b0, c0, d0;
  logic f0_1, f1_1, f2_1, f0_0, f1_0, f2_0;
  logic [3:0]  idx1, idx0;
  logic        busy1, busy0, done1, done0;
  logic [15:0] tt0_1, tt1_1, tt2_1, tt0_0, tt1_0, tt2_0;
  logic [2:0]  mism1, mism0;

  logic [15:0] f1_tab = 16'hEDE0;
  logic [15:0] f2_tab = 16'hF3CC;

  // Downstream K-map logic: F_0 is 4-input parity, F_1/F_2 from minterm tables
  assign f0_1 = a1 ^ b1 ^ c1 ^ d1;
  assign f1_1 = force_f1 ? 1'b0 : f1_tab[{a1, b1, c1, d1}];
  assign f2_1 = f2_tab[{a1, b1, c1, d1}];
  assign f0_0 = a0 ^ b0 ^ c0 ^ d0;
  assign f1_0 = force_f1 ? 1'b0 : f1_tab[{a0, b0, c0, d0}];
  assign f2_0 = f2_tab[{a0, b0, c0, d0}];

  kmap_sweeper #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .hold(hold1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .F_0(f0_1), .F_1(f1_1), .F_2(f2_1),
    .idx(idx1), .busy(busy1), .done(done1),
    .tt_f0(tt0_1), .tt_f1(tt1_1), .tt_f2(tt2_1), .mismatch(mism1)
  );

  kmap_sweeper #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start0), .hold(hold0),
    .A(a0), .B(b0), .C(c0), .D(d0),
    .F_0(f0_0), .F_1(f1_0), .F_2(f2_0),
    .idx(idx0), .busy(busy0), .done(done0),
    .tt_f0(tt0_0), .tt_f1(tt1_0), .tt_f2(tt2_0), .mismatch(mism0)
  );

  typedef struct {
    bit          settle1;
    int          hold_len;
    bit          restart;
    bit          force_f1;
    int          exp_cycles;
    logic [15:0] f0;
    logic [15:0] f1;
    logic [15:0] f2;
    logic [2:0]  mism;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_rec(input vec_t v);
    vec_t        e;
    int          n;
    int          hold_left;
    bit          held, restarted, seen_done;
    logic [15:0] s_f0, s_f1, s_f2;
    sb.push_back(v);
    force_f1 = v.force_f1;
    @(negedge clk);
    if (v.settle1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start0 = 1'b0;
    n = 1;
    check("busy_after_start", v.settle1 ? busy1 : busy0, 1);
    check("mism_cleared", v.settle1 ? mism1 : mism0, 0);
    hold_left = 0; held = 0; restarted = 0; seen_done = 0;
    while (n < 300) begin
      start1 = 1'b0;
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) hold1 = 1'b0;
      end else if (v.hold_len > 0 && !held && idx1 == 4'd7) begin
        hold1 = 1'b1;
        held = 1;
        hold_left = v.hold_len;
      end
      if (v.restart && !restarted && idx1 == 4'd9) begin
        start1 = 1'b1;
        restarted = 1;
      end
      if (!v.settle1 && n <= 16)
        check("s0_vector", {28'd0, a0, b0, c0, d0}, n - 1);
      if (v.settle1 ? done1 : done0) begin
        seen_done = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    start1 = 1'b0;
    hold1 = 1'b0;
    if (!seen_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected at %0d", n, v.exp_cycles);
      return;
    end
    e = sb.pop_front();
    check("done_cycle", n, e.exp_cycles);
    check("busy_in_done", v.settle1 ? busy1 : busy0, 1);
    s_f0 = v.settle1 ? tt0_1 : tt0_0;
    s_f1 = v.settle1 ? tt1_1 : tt1_0;
    s_f2 = v.settle1 ? tt2_1 : tt2_0;
    check("tt_f0", s_f0, e.f0);
    check("tt_f1", s_f1, e.f1);
    check("tt_f2", s_f2, e.f2);
    @(negedge clk);
    force_f1 = 1'b0;
    check("done_pulse_width", v.settle1 ? done1 : done0, 0);
    check("busy_idle", v.settle1 ? busy1 : busy0, 0);
    check("mismatch", v.settle1 ? mism1 : mism0, e.mism);
    repeat (3) @(negedge clk);
    check("no_extra_done", v.settle1 ? done1 : done0, 0);
    check("idx_final", v.settle1 ? idx1 : idx0, 15);
    check("vec_final", v.settle1 ? {a1, b1, c1, d1} : {a0, b0, c0, d0}, 15);
    check("tt_f0_retained", v.settle1 ? tt0_1 : tt0_0, e.f0);
    check("mismatch_held", v.settle1 ? mism1 : mism0, e.mism);
  endtask

  initial begin
    bit   chk_en;
    logic [2:0] m_force;
    int   n;
`ifdef KMAP_SWEEP_CHECK_EN
    chk_en = 1;
`else
    chk_en = 0;
`endif
    m_force = chk_en ? 3'b010 : 3'b000;
    //         settle1 hold rst  frc  cyc  f0        f1        f2        mism
    vecs[0] = '{1'b1,  0,   1'b0, 1'b0, 33, 16'h6996, 16'hEDE0, 16'hF3CC, 3'b000};
    vecs[1] = '{1'b0,  0,   1'b0, 1'b0, 17, 16'h6996, 16'hEDE0, 16'hF3CC, 3'b000};
    vecs[2] = '{1'b1,  5,   1'b0, 1'b0, 38, 16'h6996, 16'hEDE0, 16'hF3CC, 3'b000};
    vecs[3] = '{1'b1,  0,   1'b1, 1'b0, 33, 16'h6996, 16'hEDE0, 16'hF3CC, 3'b000};
    vecs[4] = '{1'b1,  0,   1'b0, 1'b1, 33, 16'h6996, 16'h0000, 16'hF3CC, m_force};
    vecs[5] = '{1'b0,  0,   1'b0, 1'b0, 17, 16'h6996, 16'hEDE0, 16'hF3CC, 3'b000};

    rst = 1'b1; start1 = 1'b0; hold1 = 1'b0; start0 = 1'b0; hold0 = 1'b0; force_f1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_idx", idx1, 0);
    check("rst_vec", {a1, b1, c1, d1}, 0);
    check("rst_busy_done", {busy1, done1, busy0, done0}, 0);
    check("rst_tt", {tt0_1, tt1_1}, 0);
    check("rst_mism", mism1, 0);
    // start must have no effect while reset is held
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("rst_over_start", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_rec(vecs[i]);

    // Abort mid-sweep at idx=4
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (idx1 != 4'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx4", idx1, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_idx", idx1, 0);
    check("abort_vec", {a1, b1, c1, d1}, 0);
    check("abort_busy_done", {busy1, done1}, 0);
    check("abort_tt", {tt0_1, tt1_1, tt2_1}, 0);
    check("abort_mism", mism1, 0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 || busy1) n++;
    end
    check("abort_no_done", n, 0);
    run_rec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/kmap_sweeper.md
KMAP_SWEEPER -- requirements
Module: kmap_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 0..7: extra wait cycles between driving a vector and sampling results.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, sweep request; sampled only in IDLE.
REQ-005 SHALL have port hold, input, 1, pauses an active sweep while high.
REQ-006 SHALL have ports A, B, C, D, output, 1 each, the stimulus vector driven to the downstream K-map logic; {A,B,C,D} = idx.
REQ-007 SHALL have ports F_0, F_1, F_2, input, 1 each, the combinational results returned by the K-map logic.
REQ-008 SHALL have port idx, output, 4, the current vector index.
REQ-009 SHALL have port busy, output, 1, high in states DRIVE and DONE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at sweep completion.
REQ-011 SHALL have ports tt_f0, tt_f1, tt_f2, output, 16 each, captured truth tables; bit n = F_x for idx n.
REQ-012 SHALL have port mismatch, output, 3, per-function golden-compare flags (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-014 IDLE: start=1 -> DRIVE next cycle, idx=0, settle counter=0, tt_f0/tt_f1/tt_f2 cleared to 0, mismatch cleared.
REQ-015 DRIVE: A..D SHALL be registered from idx, so they are stable for the whole vector period of SETTLE+1 cycles.
REQ-016 Settle counter SHALL increment each non-held DRIVE cycle; when counter==SETTLE, the cycle SHALL be the sample cycle.
REQ-017 Sample cycle: tt_fx[idx] <= F_x for x=0..2; counter <= 0; if idx==15 -> DONE, else idx <= idx+1.
REQ-018 A sweep without hold SHALL take exactly 16*(SETTLE+1) DRIVE cycles; done asserts on the following cycle.
REQ-019 hold=1 in DRIVE SHALL freeze idx, counter and tt_* with no sample; resumes at the same counter value when hold falls.
REQ-020 DONE SHALL last exactly one cycle with done=1, then go to IDLE; hold is ignored in DONE.
REQ-021 start SHALL be ignored while busy=1; no restart and no clearing of tt_*.
REQ-022 tt_*, idx and A..D SHALL retain their final values in IDLE until the next accepted start; after a full sweep idx=15.
REQ-023 idx wrap SHALL NOT occur; idx never increments past 15.

Reset
REQ-024 rst=1 SHALL force, on the next clock edge: state IDLE, idx=0, A=B=C=D=0, counter=0, busy=0, done=0, tt_f0=tt_f1=tt_f2=16'h0000, mismatch=3'b000.
REQ-025 rst SHALL override start, hold and any state, including a mid-sweep or DONE cycle; no done pulse is produced for an aborted sweep.

Configuration
REQ-026 Macro KMAP_SWEEP_CHECK_EN defined: in the DONE cycle, mismatch[0] <= (tt_f0 != 16'h6996), mismatch[1] <= (tt_f1 != 16'hEDE0), mismatch[2] <= (tt_f2 != 16'hF3CC); mismatch holds until the next start or rst.
REQ-027 Macro undefined: mismatch SHALL be constant 3'b000 and no compare logic is synthesized.

Verification
REQ-028 rst, then start pulse with SETTLE=1 and correct K-map attached -> done at cycle 33 after start; tt_f0=16'h6996, tt_f1=16'hEDE0, tt_f2=16'hF3CC.
REQ-029 SETTLE=0 sweep -> done 17 cycles after start; A..D step 0000..1111 one vector per cycle.
REQ-030 hold high for 5 cycles at idx=7 -> total sweep lengthened by exactly 5 cycles; tt_* identical to REQ-028.
REQ-031 start re-pulsed at idx=9 -> ignored; sweep completes normally with a single done pulse.
REQ-032 rst asserted at idx=4 -> next cycle all outputs at reset values; no done; new start performs a full sweep.
REQ-033 KMAP_SWEEP_CHECK_EN defined, F_1 forced to 0 -> after done, mismatch=3'b010; macro undefined -> mismatch=3'b000.
